// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame bridge.
package uart_frame_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  localparam int TX_FULL_BIT = 1;
  localparam int RX_EMPTY_BIT = 0;

  typedef enum logic [2:0] {
    T_LOAD,
    T_SOF,
    T_LEN,
    T_PAY,
    T_CHK,
    T_GAP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_POP,
    R_CAP,
    R_GAP,
    R_SOF,
    R_LEN,
    R_PAY,
    R_CHK,
    R_OUT
  } rx_state_t;

  function automatic logic [7:0] chk_upd(
    input logic [7:0] acc,
    input logic [7:0] b
  );
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Frame payload store: one write port, one combinational read port.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Contents are don't-care after reset, so the array has no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_bridge.sv
// Bridges payload streams to the UART FIFO register port.
// TX wraps frames as SOF/LEN/payload/CHK; RX parses, checks, forwards.
module uart_frame_bridge
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN    = 16,
  parameter int         STATUS_GAP = 2,
  parameter logic [7:0] SOF_BYTE   = SOF_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       uart_write_data,
  output logic [7:0] uart_wdata,
  output logic       uart_read_data,
  input  logic [7:0] uart_rdata,
  input  logic [7:0] uart_tx_status,
  input  logic [7:0] uart_rx_status,
  output logic [7:0] frame_err_cnt
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  localparam logic [7:0] GAP_END = 8'(STATUS_GAP - 1);

  logic unused_status;
  assign unused_status = ^{uart_tx_status, uart_rx_status};

  tx_state_t  tx_st_q, tx_st_d;
  tx_state_t  tx_nxt_q, tx_nxt_d;
  tx_state_t  tx_emit_n;
  logic [7:0] tx_cnt_q, tx_cnt_d;
  logic [7:0] tx_idx_q, tx_idx_d;
  logic [7:0] tx_chk_q, tx_chk_d;
  logic [7:0] tx_gap_q, tx_gap_d;
  logic [7:0] tx_rdata, tx_emit_b;
  logic       tx_we, tx_push, s_rdy;

  uart_frame_buf #(
    .DEPTH(MAX_LEN),
    .AW   (AW)
  ) u_tx_buf (
    .clk  (clk),
    .we   (tx_we),
    .waddr(tx_cnt_q[AW-1:0]),
    .wdata(s_data),
    .raddr(tx_idx_q[AW-1:0]),
    .rdata(tx_rdata)
  );

  always_comb begin
    tx_emit_b = SOF_BYTE;
    tx_emit_n = T_LEN;
    unique case (tx_st_q)
      T_LEN: begin
        tx_emit_b = tx_cnt_q;
        tx_emit_n = T_PAY;
      end
      T_PAY: begin
        tx_emit_b = tx_rdata;
        tx_emit_n = (tx_idx_q == tx_cnt_q - 8'd1)
                  ? T_CHK : T_PAY;
      end
      T_CHK: begin
        tx_emit_b = chk_upd(tx_chk_q, tx_cnt_q);
        tx_emit_n = T_LOAD;
      end
      default: ;
    endcase
  end

  always_comb begin
    tx_st_d    = tx_st_q;
    tx_nxt_d   = tx_nxt_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_chk_d   = tx_chk_q;
    tx_gap_d   = tx_gap_q;
    tx_we      = 1'b0;
    tx_push    = 1'b0;
    s_rdy      = 1'b0;
    uart_wdata = 8'h00;
    unique case (tx_st_q)
      T_LOAD: begin
        s_rdy = 1'b1;
        if (s_valid) begin
          tx_we    = 1'b1;
          tx_cnt_d = tx_cnt_q + 8'd1;
          tx_chk_d = chk_upd(tx_chk_q, s_data);
          if (s_last || tx_cnt_q == MAX_B - 8'd1)
            tx_st_d = T_SOF;
        end
      end
      T_GAP: begin
        if (tx_gap_q == GAP_END) begin
          tx_st_d = tx_nxt_q;
          if (tx_nxt_q == T_LOAD) begin
            tx_cnt_d = 8'h00;
            tx_chk_d = 8'h00;
          end
        end else begin
          tx_gap_d = tx_gap_q + 8'd1;
        end
      end
      default: begin
        // Emit states share one push path; the byte comes from tx_emit_b.
        if (!uart_tx_status[TX_FULL_BIT]) begin
          tx_push    = 1'b1;
          uart_wdata = tx_emit_b;
          tx_nxt_d   = tx_emit_n;
          tx_gap_d   = 8'h00;
          tx_st_d    = T_GAP;
          if (tx_st_q == T_LEN) tx_idx_d = 8'h00;
          if (tx_st_q == T_PAY) tx_idx_d = tx_idx_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st_q  <= T_LOAD;
      tx_nxt_q <= T_LOAD;
      tx_cnt_q <= 8'h00;
      tx_idx_q <= 8'h00;
      tx_chk_q <= 8'h00;
      tx_gap_q <= 8'h00;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_nxt_q <= tx_nxt_d;
      tx_cnt_q <= tx_cnt_d;
      tx_idx_q <= tx_idx_d;
      tx_chk_q <= tx_chk_d;
      tx_gap_q <= tx_gap_d;
    end
  end

  assign s_ready = s_rdy & ~reset;
  assign uart_write_data = tx_push;

  rx_state_t  rx_st_q, rx_st_d;
  rx_state_t  rx_ph_q, rx_ph_d;
  logic [7:0] rx_dat_q, rx_dat_d;
  logic [7:0] rx_len_q, rx_len_d;
  logic [7:0] rx_idx_q, rx_idx_d;
  logic [7:0] rx_chk_q, rx_chk_d;
  logic [7:0] rx_gap_q, rx_gap_d;
  logic [7:0] err_q, err_d;
  logic [7:0] rx_rdata;
  logic       rx_we, rx_pop, rx_err, rx_mv, rx_ml;

  uart_frame_buf #(
    .DEPTH(MAX_LEN),
    .AW   (AW)
  ) u_rx_buf (
    .clk  (clk),
    .we   (rx_we),
    .waddr(rx_idx_q[AW-1:0]),
    .wdata(rx_dat_q),
    .raddr(rx_idx_q[AW-1:0]),
    .rdata(rx_rdata)
  );

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_ph_d  = rx_ph_q;
    rx_dat_d = rx_dat_q;
    rx_len_d = rx_len_q;
    rx_idx_d = rx_idx_q;
    rx_chk_d = rx_chk_q;
    rx_gap_d = rx_gap_q;
    rx_we    = 1'b0;
    rx_pop   = 1'b0;
    rx_err   = 1'b0;
    rx_mv    = 1'b0;
    rx_ml    = 1'b0;
    unique case (rx_st_q)
      R_POP: begin
        if (!uart_rx_status[RX_EMPTY_BIT]) begin
          rx_pop  = 1'b1;
          rx_st_d = R_CAP;
        end
      end
      R_CAP: begin
        rx_dat_d = uart_rdata;
        rx_gap_d = 8'h00;
        rx_st_d  = R_GAP;
      end
      R_GAP: begin
        if (rx_gap_q == GAP_END) rx_st_d = rx_ph_q;
        else rx_gap_d = rx_gap_q + 8'd1;
      end
      R_SOF: begin
        rx_st_d = R_POP;
        if (rx_dat_q == SOF_BYTE) rx_ph_d = R_LEN;
      end
      R_LEN: begin
        rx_st_d = R_POP;
        if (rx_dat_q == 8'h00 || rx_dat_q > MAX_B) begin
          rx_err  = 1'b1;
          rx_ph_d = R_SOF;
        end else begin
          rx_len_d = rx_dat_q;
          rx_chk_d = rx_dat_q;
          rx_idx_d = 8'h00;
          rx_ph_d  = R_PAY;
        end
      end
      R_PAY: begin
        rx_st_d  = R_POP;
        rx_we    = 1'b1;
        rx_chk_d = chk_upd(rx_chk_q, rx_dat_q);
        if (rx_idx_q == rx_len_q - 8'd1) rx_ph_d = R_CHK;
        else rx_idx_d = rx_idx_q + 8'd1;
      end
      R_CHK: begin
        if (rx_dat_q == rx_chk_q) begin
          rx_idx_d = 8'h00;
          rx_st_d  = R_OUT;
        end else begin
          rx_err  = 1'b1;
          rx_ph_d = R_SOF;
          rx_st_d = R_POP;
        end
      end
      R_OUT: begin
        rx_mv = 1'b1;
        rx_ml = (rx_idx_q == rx_len_q - 8'd1);
        if (m_ready) begin
          if (rx_ml) begin
            rx_ph_d = R_SOF;
            rx_st_d = R_POP;
          end else begin
            rx_idx_d = rx_idx_q + 8'd1;
          end
        end
      end
      default: rx_st_d = R_POP;
    endcase
    err_d = (rx_err && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_st_q  <= R_POP;
      rx_ph_q  <= R_SOF;
      rx_dat_q <= 8'h00;
      rx_len_q <= 8'h00;
      rx_idx_q <= 8'h00;
      rx_chk_q <= 8'h00;
      rx_gap_q <= 8'h00;
      err_q    <= 8'h00;
    end else begin
      rx_st_q  <= rx_st_d;
      rx_ph_q  <= rx_ph_d;
      rx_dat_q <= rx_dat_d;
      rx_len_q <= rx_len_d;
      rx_idx_q <= rx_idx_d;
      rx_chk_q <= rx_chk_d;
      rx_gap_q <= rx_gap_d;
      err_q    <= err_d;
    end
  end

  assign uart_read_data = rx_pop & ~reset;
  assign m_valid = rx_mv;
  assign m_data = rx_mv ? rx_rdata : 8'h00;
  assign m_last = rx_ml;
  assign frame_err_cnt = err_q;

endmodule

// File: tb/tb_uart_frame_bridge.sv
// Randomized bench for uart_frame_bridge with FIFO models
// and a frame-level reference model for both directions.
module tb_uart_frame_bridge;

  localparam int MAX_LEN = 16;
  localparam int GAP = 2;
  localparam logic [7:0] SOF = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready = 1'b0;
  logic       uart_write_data;
  logic [7:0] uart_wdata;
  logic       uart_read_data;
  logic [7:0] uart_rdata = 8'h00;
  logic [7:0] uart_tx_status = 8'h00;
  logic [7:0] uart_rx_status = 8'h01;
  logic [7:0] frame_err_cnt;

  always #5 clk = ~clk;

  uart_frame_bridge #(
    .MAX_LEN   (MAX_LEN),
    .STATUS_GAP(GAP),
    .SOF_BYTE  (SOF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .uart_write_data(uart_write_data),
    .uart_wdata     (uart_wdata),
    .uart_read_data (uart_read_data),
    .uart_rdata     (uart_rdata),
    .uart_tx_status (uart_tx_status),
    .uart_rx_status (uart_rx_status),
    .frame_err_cnt  (frame_err_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [8:0] mq[$];
  logic [7:0] exp_tx[$];
  logic [8:0] exp_m[$];
  int exp_err = 0;
  int last_wr = -100;
  int last_rd = -100;
  int viol_gap = 0;
  int viol_full = 0;
  int viol_stab = 0;
  bit pend = 0;
  bit hold_p = 0;
  logic [8:0] hold_v;
  int rdy_mode = 2;

  always @(negedge clk) begin
    if (reset) begin
      hold_p = 0;
    end else begin
      if (uart_write_data) begin
        txq.push_back(uart_wdata);
        if (cyc - last_wr < GAP + 1) viol_gap++;
        if (uart_tx_status[1]) viol_full++;
        last_wr = cyc;
      end
      if (uart_read_data) begin
        if (cyc - last_rd < GAP + 1) viol_gap++;
        last_rd = cyc;
        pend = 1;
      end
      if (hold_p && (!m_valid || {m_last, m_data} != hold_v))
        viol_stab++;
      if (m_valid && m_ready) mq.push_back({m_last, m_data});
      hold_p = m_valid && !m_ready;
      hold_v = {m_last, m_data};
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (pend) begin
      pend = 0;
      if (rxq.size() > 0) uart_rdata = rxq.pop_front();
    end
    uart_rx_status = {7'd0, rxq.size() == 0};
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rdy_mode == 2) m_ready = 1'b1;
    else if (rdy_mode == 1) m_ready = 1'($urandom_range(0, 1));
    else m_ready = 1'b0;
  end

  task automatic model_tx(input logic [8:0] b[$]);
    logic [7:0] pay[$];
    logic [7:0] x;
    foreach (b[i]) begin
      pay.push_back(b[i][7:0]);
      if (b[i][8] || pay.size() == MAX_LEN) begin
        x = 8'(pay.size());
        exp_tx.push_back(SOF);
        exp_tx.push_back(x);
        foreach (pay[k]) begin
          exp_tx.push_back(pay[k]);
          x = x ^ pay[k];
        end
        exp_tx.push_back(x);
        pay.delete();
      end
    end
  endtask

  task automatic model_rx(input logic [7:0] s[$]);
    int i, n, len;
    logic [7:0] x;
    i = 0;
    n = s.size();
    while (i < n) begin
      if (s[i] != SOF) begin
        i++;
      end else if (i + 1 >= n) begin
        i = n;
      end else begin
        len = s[i+1];
        if (len == 0 || len > MAX_LEN) begin
          if (exp_err < 255) exp_err++;
          i += 2;
        end else if (i + 2 + len >= n) begin
          i = n;
        end else begin
          x = 8'(len);
          for (int k = 0; k < len; k++) x = x ^ s[i+2+k];
          if (x == s[i+2+len]) begin
            for (int k = 0; k < len; k++)
              exp_m.push_back({k == len - 1, s[i+2+k]});
          end else if (exp_err < 255) begin
            exp_err++;
          end
          i += 3 + len;
        end
      end
    end
  endtask

  task automatic send(input logic [8:0] b[$]);
    int t;
    bit ok;
    foreach (b[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data = b[i][7:0];
      s_last = b[i][8];
      t = 0;
      ok = 0;
      while (!ok && t < 500) begin
        @(negedge clk);
        ok = s_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!ok) chk("s_ready_timeout", 0, 1);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic tx_frame(input int len, input bit last);
    logic [8:0] b[$];
    for (int i = 0; i < len; i++)
      b.push_back({last && i == len - 1, 8'($urandom)});
    model_tx(b);
    send(b);
  endtask

  task automatic feed(input logic [7:0] s[$]);
    foreach (s[i]) rxq.push_back(s[i]);
    model_rx(s);
  endtask

  task automatic wait_tx(input string tag);
    int t;
    t = 0;
    while (txq.size() < exp_tx.size() && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (30) @(posedge clk);
    #1;
    chk({tag, "_count"}, txq.size(), exp_tx.size());
    foreach (exp_tx[i])
      chk($sformatf("%s[%0d]", tag, i),
          i < txq.size() ? int'(txq[i]) : -1, exp_tx[i]);
    txq.delete();
    exp_tx.delete();
  endtask

  task automatic wait_rx(input string tag);
    int t;
    t = 0;
    while ((rxq.size() > 0 || mq.size() < exp_m.size()) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (30) @(posedge clk);
    #1;
    chk({tag, "_drain"}, rxq.size(), 0);
    chk({tag, "_count"}, mq.size(), exp_m.size());
    foreach (exp_m[i])
      chk($sformatf("%s[%0d]", tag, i),
          i < mq.size() ? int'(mq[i]) : -1, exp_m[i]);
    chk({tag, "_err"}, frame_err_cnt, exp_err);
    mq.delete();
    exp_m.delete();
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_s_ready"}, s_ready, 0);
    chk({p, "_m_valid"}, m_valid, 0);
    chk({p, "_m_data"}, m_data, 0);
    chk({p, "_m_last"}, m_last, 0);
    chk({p, "_wr"}, uart_write_data, 0);
    chk({p, "_wdata"}, uart_wdata, 0);
    chk({p, "_rd"}, uart_read_data, 0);
    chk({p, "_err"}, frame_err_cnt, 0);
  endtask

  function automatic logic [7:0] junk();
    logic [7:0] j;
    j = 8'($urandom_range(0, 254));
    if (j >= SOF) j = j + 8'd1;
    return j;
  endfunction

  task automatic rand_rx_frame();
    logic [7:0] s[$];
    logic [7:0] x;
    int kind, len;
    repeat ($urandom_range(0, 2)) s.push_back(junk());
    kind = $urandom_range(0, 4);
    s.push_back(SOF);
    if (kind == 4) begin
      s.push_back($urandom_range(0, 1) ? 8'h00
                  : 8'($urandom_range(MAX_LEN + 1, 255)));
    end else begin
      len = $urandom_range(1, MAX_LEN);
      x = 8'(len);
      s.push_back(x);
      for (int i = 0; i < len; i++) begin
        s.push_back(8'($urandom));
        x = x ^ s[s.size()-1];
      end
      if (kind == 3) x = x ^ 8'($urandom_range(1, 255));
      s.push_back(x);
    end
    feed(s);
  endtask

  initial begin
    int n, t;
    logic [8:0] d1[$];
    logic [7:0] r[$];

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    d1 = '{9'h001, 9'h002, 9'h103};
    model_tx(d1);
    send(d1);
    wait_tx("tx_basic");

    tx_frame(10, 1);
    t = 0;
    while (txq.size() < 4 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    uart_tx_status[1] = 1'b1;
    n = txq.size();
    repeat (20) @(posedge clk);
    #1;
    chk("hold_no_push", txq.size(), n);
    uart_tx_status[1] = 1'b0;
    wait_tx("tx_hold");

    tx_frame(20, 1);
    tx_frame(MAX_LEN, 1);
    for (int k = 0; k < 6; k++) tx_frame($urandom_range(1, MAX_LEN), 1);
    wait_tx("tx_rand");

    rdy_mode = 2;
    r = '{8'h55, 8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    feed(r);
    wait_rx("rx_basic");
    chk("rx_basic_err0", frame_err_cnt, 0);

    r = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h33,
          8'hA5, 8'h01, 8'h7F, 8'h7E};
    feed(r);
    wait_rx("rx_badchk");
    chk("rx_badchk_err1", frame_err_cnt, 1);

    r = '{8'hA5, 8'h00, 8'hA5, 8'h11,
          8'hA5, 8'h01, 8'h42, 8'h43};
    feed(r);
    wait_rx("rx_badlen");

    rdy_mode = 1;
    for (int k = 0; k < 25; k++) rand_rx_frame();
    wait_rx("rx_rand");

    rdy_mode = 0;
    r = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'hFF,
          8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    feed(r);
    t = 0;
    while (!m_valid && t < 1000) begin
      @(posedge clk);
      t++;
    end
    chk("pre_reset_m_valid", m_valid, 1);
    @(posedge clk);
    #1;
    tx_frame(8, 1);
    t = 0;
    while (txq.size() < 5 && t < 500) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    repeat (3) @(posedge clk);
    txq.delete();
    rxq.delete();
    mq.delete();
    exp_tx.delete();
    exp_m.delete();
    exp_err = 0;
    pend = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    rdy_mode = 1;
    tx_frame(5, 1);
    wait_tx("tx_post");
    rand_rx_frame();
    r = '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
    feed(r);
    wait_rx("rx_post");

    chk("gap_violations", viol_gap, 0);
    chk("full_violations", viol_full, 0);
    chk("stable_violations", viol_stab, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
